axi_r_burst_arbiter: RTL and testbench
======================================

Name: axi_r_burst_arbiter

Overview:
- Per-master R-channel arbiter for the interconnect read-response path.
- Chooses one of NumSlaves slaves with a valid beat routed to this master.
- Holds that grant until the burst's rlast beat has been accepted, so bursts from different slaves never interleave.
- Drives the mux/demux select lines and per-slave rready; one instance per master, placed between the slave-side demuxes and the master-side skid buffer.

Parameters:
- NumSlaves, 2, number of requesting slaves (>=1).
- MaxBeats, 256, AXI4 maximum burst length; watchdog limit for a locked burst.
- GrantWidth, derived: $clog2(NumSlaves), or 1 when NumSlaves==1; binary grant width.

Ports:
- aclk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- rvalid_i  input  NumSlaves  per-slave rvalid for beats addressed to this master.
- rlast_i  input  NumSlaves  per-slave rlast.
- rready_i  input  1  ready from the downstream skid buffer.
- grant_o  output  NumSlaves  one-hot grant; all zeros when nothing is granted.
- bin_grant_o  output  GrantWidth  binary index of the granted slave; 0 when grant_o is zero.
- rvalid_o  output  1  rvalid of the granted slave.
- rready_o  output  NumSlaves  rready_i routed to the granted slave only; 0 elsewhere.
- locked_o  output  1  high while in LOCKED.
- beat_cnt_o  output  $clog2(MaxBeats+1)  beats accepted in the current burst.
- err_o  output  1  sticky watchdog error.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE, ptr=0, lock_idx=0, beat_cnt=0, err=0.
  - Outputs: grant_o=0, bin_grant_o=0, rvalid_o=0, rready_o=0, locked_o=0, beat_cnt_o=0, err_o=0.
  - Outputs in the cycle after reset reflect IDLE logic with ptr=0.
  - Reset in mid-burst drops the lock unconditionally.
- Beat acceptance: accept = rvalid_o && rready_i, i.e. the granted slave's rvalid and rready_i are both high.
- IDLE:
  - Grant is combinational from rvalid_i with zero latency.
  - Round-robin pick: the first set bit at index ptr, ptr+1, ..., wrapping from NumSlaves-1 to 0.
  - No request: grant_o=0.
  - accept with rlast: stay IDLE, ptr<=(g+1) mod NumSlaves, beat_cnt<=0.
  - accept without rlast: go to LOCKED, lock_idx<=g, beat_cnt<=1.
  - No accept: no state change, and the grant may change next cycle.
- LOCKED:
  - grant_o=onehot(lock_idx), whatever rvalid_i shows; other slaves' requests are ignored.
  - rvalid_o=rvalid_i[lock_idx], which may be 0 during bubbles with the lock held.
  - accept without rlast: beat_cnt<=beat_cnt+1.
  - accept with rlast: go to IDLE, ptr<=(lock_idx+1) mod NumSlaves, beat_cnt<=0.
- Watchdog:
  - Trigger: an accepted non-last beat that would make beat_cnt==MaxBeats.
  - Action: err<=1 (sticky until reset), force IDLE, ptr<=lock_idx+1, beat_cnt<=0.
- rready_o[k] = rready_i && grant_o[k]; it is never high for an ungranted slave.
- Single-beat bursts (rlast on the first beat) never enter LOCKED.
- NumSlaves==1: grant_o=rvalid_i[0] in IDLE; ptr stays 0; bin_grant_o is 1 bit and always 0.
- No combinational path from rready_i to grant_o or bin_grant_o; grant depends only on rvalid_i and state.

Decomposition:
- Shared package axi_ic_pkg:
  - r_arb_state_e enum {IDLE, LOCKED};
  - grant-width helper function (clog2 with minimum 1).
- Sub-module axi_rr_pick:
  - combinational masked priority encoder;
  - inputs req and ptr; outputs one-hot and binary index;
  - reusable for the B-channel arbiter.

Test Plan:
- NumSlaves=2, rready_i=1, slave0 sends a 4-beat burst while slave1 is held valid → grant_o=01 for 4 cycles, locked_o=1 after beat 1, beat_cnt_o 1,2,3 then 0; grant_o=10 in the cycle after rlast.
- Both slaves issue continuous single-beat bursts → grants alternate 01,10,01,10; locked_o stays 0.
- Slave1 in a 3-beat burst with rready_i=0 for 2 cycles mid-burst, slave0 asserting valid → grant_o held at 10, rready_o=00 during the stall, burst completes, then slave0 is granted.
- NumSlaves=4, ptr=3 after a slave2 burst, requests from slaves 0 and 1 → slave0 granted (wrap-around), bin_grant_o=0.
- MaxBeats=4, slave0 sends 5 beats without rlast → on the 4th accepted beat err_o=1, locked_o=0 next cycle, err_o stays 1.
- rst_n low on beat 2 of a 4-beat burst → next cycle grant_o=00, beat_cnt_o=0, locked_o=0, err_o=0; an immediate request from slave1 is granted with ptr=0 priority.

Source files
------------

// File: rtl/axi_ic_pkg.sv
// Shared types and helpers for the interconnect arbiters.
package axi_ic_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } r_arb_state_e;

  // Binary index width for n requesters, never narrower than one bit.
  function automatic int grant_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_rr_pick.sv
// Round-robin pick: first set request at index ptr, ptr+1, ... with wrap-around.
// Purely combinational; shared by the R- and B-channel arbiters.
module axi_rr_pick
  import axi_ic_pkg::*;
#(
  parameter int NumReq   = 2,
  parameter int IdxWidth = grant_width(NumReq)
) (
  input  logic [NumReq-1:0]   req,
  input  logic [IdxWidth-1:0] ptr,
  output logic [NumReq-1:0]   onehot,
  output logic [IdxWidth-1:0] idx
);

  logic [NumReq-1:0] masked;
  logic [NumReq-1:0] pool;

  // Requests at or above ptr win; if none, wrap to the lowest request overall.
  always_comb begin
    masked = '0;
    for (int k = 0; k < NumReq; k++) begin
      masked[k] = req[k] && (k >= int'(ptr));
    end
    pool   = (|masked) ? masked : req;
    onehot = '0;
    idx    = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (pool[k]) begin
        onehot    = '0;
        onehot[k] = 1'b1;
        idx       = IdxWidth'(k);
      end
    end
  end

endmodule

// File: rtl/axi_r_burst_arbiter.sv
// Per-master R-channel arbiter: round-robin between slaves, holding the grant
// for a whole burst so beats from different slaves never interleave.
//
//   state  | meaning
//   IDLE   | no burst open; grant follows rvalid_i round-robin from ptr
//   LOCKED | burst from lock_idx in progress; grant pinned until rlast
module axi_r_burst_arbiter
  import axi_ic_pkg::*;
#(
  parameter int NumSlaves  = 2,
  parameter int MaxBeats   = 256,
  parameter int GrantWidth = grant_width(NumSlaves)
) (
  input  logic                          aclk,
  input  logic                          rst_n,
  input  logic [NumSlaves-1:0]          rvalid_i,
  input  logic [NumSlaves-1:0]          rlast_i,
  input  logic                          rready_i,
  output logic [NumSlaves-1:0]          grant_o,
  output logic [GrantWidth-1:0]         bin_grant_o,
  output logic                          rvalid_o,
  output logic [NumSlaves-1:0]          rready_o,
  output logic                          locked_o,
  output logic [$clog2(MaxBeats+1)-1:0] beat_cnt_o,
  output logic                          err_o
);

  localparam int CntWidth = $clog2(MaxBeats + 1);

  r_arb_state_e          state;
  logic [GrantWidth-1:0] ptr;
  logic [GrantWidth-1:0] lock_idx;
  logic [CntWidth-1:0]   beat_cnt;
  logic                  err;

  logic [NumSlaves-1:0]  pick_onehot;
  logic [GrantWidth-1:0] pick_idx;
  logic [NumSlaves-1:0]  grant;
  logic [GrantWidth-1:0] bin_grant;
  logic [GrantWidth-1:0] ptr_inc;
  logic                  granted_last;
  logic                  accept;
  logic                  watchdog;

  axi_rr_pick #(
    .NumReq   (NumSlaves),
    .IdxWidth (GrantWidth)
  ) u_pick (
    .req    (rvalid_i),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  // Grant depends only on rvalid_i and state; rready_i never feeds back into it.
  always_comb begin
    grant     = pick_onehot;
    bin_grant = pick_idx;
    if (state == LOCKED) begin
      for (int k = 0; k < NumSlaves; k++) begin
        grant[k] = (int'(lock_idx) == k);
      end
      bin_grant = lock_idx;
    end
  end

  assign granted_last = |(rlast_i & grant);
  assign rvalid_o     = |(rvalid_i & grant);
  assign accept       = rvalid_o && rready_i;
  assign watchdog     = accept && !granted_last && (int'(beat_cnt) + 1 == MaxBeats);
  assign ptr_inc      = (int'(bin_grant) == NumSlaves - 1) ? '0 : bin_grant + GrantWidth'(1);

  assign grant_o     = grant;
  assign bin_grant_o = bin_grant;
  assign rready_o    = grant & {NumSlaves{rready_i}};
  assign locked_o    = (state == LOCKED);
  assign beat_cnt_o  = beat_cnt;
  assign err_o       = err;

  // Burst tracking: a closing beat (rlast or watchdog) advances the pointer
  // past the winner; any other accepted beat opens or extends the lock.
  always_ff @(posedge aclk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      lock_idx <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else if (accept) begin
      if (granted_last || watchdog) begin
        state    <= IDLE;
        ptr      <= ptr_inc;
        beat_cnt <= '0;
        if (watchdog) err <= 1'b1;
      end else begin
        state    <= LOCKED;
        lock_idx <= bin_grant;
        beat_cnt <= beat_cnt + CntWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_r_burst_arbiter.sv
// Directed bench for axi_r_burst_arbiter: a 2-slave instance with a short
// watchdog limit and a 4-slave instance for wrap-around arbitration.
module tb_axi_r_burst_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0] rv2, rl2, gr2, ro2;
  logic       rr2, bg2, vo2, lk2, er2;
  logic [2:0] bc2;

  logic [3:0] rv4, rl4, gr4, ro4;
  logic       rr4, vo4, lk4, er4;
  logic [1:0] bg4;
  logic [8:0] bc4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_r_burst_arbiter #(.NumSlaves(2), .MaxBeats(4)) u_dut2 (
    .aclk(clk), .rst_n(rst_n), .rvalid_i(rv2), .rlast_i(rl2), .rready_i(rr2),
    .grant_o(gr2), .bin_grant_o(bg2), .rvalid_o(vo2), .rready_o(ro2),
    .locked_o(lk2), .beat_cnt_o(bc2), .err_o(er2)
  );

  axi_r_burst_arbiter #(.NumSlaves(4), .MaxBeats(256)) u_dut4 (
    .aclk(clk), .rst_n(rst_n), .rvalid_i(rv4), .rlast_i(rl4), .rready_i(rr4),
    .grant_o(gr4), .bin_grant_o(bg4), .rvalid_o(vo4), .rready_o(ro4),
    .locked_o(lk4), .beat_cnt_o(bc4), .err_o(er4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rv2 = '0; rl2 = '0; rr2 = 1'b1;
    rv4 = '0; rl4 = '0; rr4 = 1'b1;
    tick; tick;
    chk("rst_grant",  32'(gr2), 32'h0);
    chk("rst_bin",    32'(bg2), 32'h0);
    chk("rst_rvalid", 32'(vo2), 32'h0);
    chk("rst_rready", 32'(ro2), 32'h0);
    chk("rst_locked", 32'(lk2), 32'h0);
    chk("rst_cnt",    32'(bc2), 32'h0);
    chk("rst_err",    32'(er2), 32'h0);
    rst_n = 1'b1;

    // 4-beat burst from slave0 while slave1 stays valid
    rv2 = 2'b11;
    for (int i = 0; i < 4; i++) begin
      rl2 = (i == 3) ? 2'b11 : 2'b10;
      #1;
      chk("t1_grant",  32'(gr2), 32'h1);
      chk("t1_rready", 32'(ro2), 32'h1);
      chk("t1_rvalid", 32'(vo2), 32'h1);
      tick;
      chk("t1_locked", 32'(lk2), (i < 3) ? 32'h1 : 32'h0);
      chk("t1_cnt",    32'(bc2), (i < 3) ? 32'(i + 1) : 32'h0);
    end
    #1;
    chk("t1_next_grant", 32'(gr2), 32'h2);
    chk("t1_next_bin",   32'(bg2), 32'h1);

    // single-beat bursts alternate between slaves (ptr is 1 here)
    rl2 = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_grant", 32'(gr2), (i % 2 == 0) ? 32'h2 : 32'h1);
      tick;
      chk("t2_locked", 32'(lk2), 32'h0);
    end

    // slave1 3-beat burst with a stall and a bubble; slave0 waiting
    rl2 = 2'b01;
    #1;
    chk("t3_grant", 32'(gr2), 32'h2);
    tick;
    chk("t3_locked", 32'(lk2), 32'h1);
    chk("t3_cnt1",   32'(bc2), 32'h1);
    rr2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3_stall_grant",  32'(gr2), 32'h2);
      chk("t3_stall_rready", 32'(ro2), 32'h0);
      tick;
      chk("t3_stall_cnt", 32'(bc2), 32'h1);
    end
    rr2 = 1'b1;
    rv2 = 2'b01;
    #1;
    chk("t3_bubble_grant",  32'(gr2), 32'h2);
    chk("t3_bubble_rvalid", 32'(vo2), 32'h0);
    chk("t3_bubble_rready", 32'(ro2), 32'h2);
    tick;
    chk("t3_bubble_cnt", 32'(bc2), 32'h1);
    rv2 = 2'b11;
    tick;
    chk("t3_cnt2", 32'(bc2), 32'h2);
    rl2 = 2'b11;
    #1;
    chk("t3_last_grant", 32'(gr2), 32'h2);
    tick;
    chk("t3_end_locked", 32'(lk2), 32'h0);
    chk("t3_end_cnt",    32'(bc2), 32'h0);
    #1;
    chk("t3_then_slave0", 32'(gr2), 32'h1);
    tick;
    chk("t3_single_locked", 32'(lk2), 32'h0);

    // watchdog: slave0 never sends rlast, limit is 4 beats
    rv2 = 2'b01;
    rl2 = 2'b00;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t5_grant", 32'(gr2), 32'h1);
      tick;
      if (i < 3) begin
        chk("t5_cnt",    32'(bc2), 32'(i + 1));
        chk("t5_locked", 32'(lk2), 32'h1);
        chk("t5_err",    32'(er2), 32'h0);
      end else begin
        chk("t5_err_set",  32'(er2), 32'h1);
        chk("t5_unlocked", 32'(lk2), 32'h0);
        chk("t5_cnt_clr",  32'(bc2), 32'h0);
      end
    end
    tick;
    chk("t5_err_sticky",   32'(er2), 32'h1);
    chk("t5_relock",       32'(lk2), 32'h1);

    // reset on beat 2 of a burst, with ptr at 1 beforehand
    rst_n = 1'b0;
    tick;
    rv2 = 2'b00;
    rst_n = 1'b1;
    #1;
    chk("t6_grant",  32'(gr2), 32'h0);
    chk("t6_cnt",    32'(bc2), 32'h0);
    chk("t6_locked", 32'(lk2), 32'h0);
    chk("t6_err",    32'(er2), 32'h0);
    rv2 = 2'b11;
    #1;
    chk("t6_ptr0_grant", 32'(gr2), 32'h1);
    chk("t6_ptr0_bin",   32'(bg2), 32'h0);
    rv2 = 2'b10;
    #1;
    chk("t6_s1_grant", 32'(gr2), 32'h2);
    chk("t6_s1_bin",   32'(bg2), 32'h1);
    rv2 = 2'b00;
    tick;

    // 4 slaves: slave2 burst leaves ptr=3, then wrap to slave0
    rv4 = 4'b0100;
    rl4 = 4'b0000;
    #1;
    chk("t4_grant2", 32'(gr4), 32'h4);
    chk("t4_bin2",   32'(bg4), 32'h2);
    tick;
    chk("t4_locked", 32'(lk4), 32'h1);
    chk("t4_cnt",    32'(bc4), 32'h1);
    rv4 = 4'b0111;
    rl4 = 4'b0100;
    #1;
    chk("t4_hold_grant",  32'(gr4), 32'h4);
    chk("t4_hold_rready", 32'(ro4), 32'h4);
    tick;
    chk("t4_unlocked", 32'(lk4), 32'h0);
    rv4 = 4'b0011;
    rl4 = 4'b0001;
    #1;
    chk("t4_wrap_grant",  32'(gr4), 32'h1);
    chk("t4_wrap_bin",    32'(bg4), 32'h0);
    chk("t4_wrap_rready", 32'(ro4), 32'h1);
    tick;
    rv4 = 4'b1101;
    #1;
    chk("t4_ptr1_grant", 32'(gr4), 32'h4);
    chk("t4_ptr1_bin",   32'(bg4), 32'h2);
    rv4 = 4'b1001;
    #1;
    chk("t4_s3_grant", 32'(gr4), 32'h8);
    chk("t4_s3_bin",   32'(bg4), 32'h3);
    rv4 = 4'b0000;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
